// File: rtl/aes_dom_seq_ctrl.sv
// Run sequencer for the byte-serial DOM AES core: stages pt/key/trigger delay, streams 16 bytes
// into the core, collects 16 ciphertext bytes, fires the scope trigger and guards with a watchdog.
module aes_dom_seq_ctrl #(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned TRG_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_we_i,
  input  logic [127:0]     ptxt_i,
  input  logic [127:0]     key_i,
  input  logic             trg_we_i,
  input  logic [TRG_W-1:0] trg_delay_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             result_valid_o,
  output logic [127:0]     ctxt_o,
  output logic             timeout_err_o,
  output logic             trg_o,
  output logic             core_start_o,
  output logic [7:0]       core_pt_o,
  output logic [7:0]       core_key_o,
  input  logic             core_done_i,
  input  logic [7:0]       core_ct_i
);

  typedef enum logic [2:0] {StIdle, StStart, StLoad, StWait, StUnload, StDone} state_e;

  localparam logic [TIMEOUT_W-1:0] WdMax  = '1;
  localparam logic [TIMEOUT_W-1:0] WdLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TRG_W-1:0]     TrgOne = {{(TRG_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [127:0]         ptxt_stage_q, key_stage_q;
  logic [127:0]         pt_sh_q, pt_sh_d, key_sh_q, key_sh_d;
  logic [127:0]         cap_q, cap_d, ctxt_q, ctxt_d;
  logic [TRG_W-1:0]     trg_dly_q, trg_cnt_q, trg_cnt_d;
  logic                 trg_q;
  logic [3:0]           byte_cnt_q, byte_cnt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 tmo_q, tmo_d;
  logic                 start_acc;

  assign start_acc = (state_q == StIdle) && start_i;

  // Staging registers are written directly; an accepted start reads the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptxt_stage_q <= '0;
      key_stage_q  <= '0;
      trg_dly_q    <= '0;
    end else begin
      if (load_we_i) begin
        ptxt_stage_q <= ptxt_i;
        key_stage_q  <= key_i;
      end
      if (trg_we_i) trg_dly_q <= trg_delay_i;
    end
  end

  always_comb begin
    if (start_acc)              trg_cnt_d = trg_dly_q;
    else if (trg_cnt_q != '0)   trg_cnt_d = trg_cnt_q - 1'b1;
    else                        trg_cnt_d = trg_cnt_q;
  end

  always_comb begin
    state_d    = state_q;
    pt_sh_d    = pt_sh_q;
    key_sh_d   = key_sh_q;
    cap_d      = cap_q;
    ctxt_d     = ctxt_q;
    byte_cnt_d = byte_cnt_q;
    wd_d       = wd_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pt_sh_d  = ptxt_stage_q;
          key_sh_d = key_stage_q;
          tmo_d    = 1'b0;
          state_d  = StStart;
        end
      end
      StStart: begin
        byte_cnt_d = 4'd0;
        state_d    = StLoad;
      end
      StLoad: begin
        pt_sh_d  = {pt_sh_q[119:0], 8'h00};
        key_sh_d = {key_sh_q[119:0], 8'h00};
        if (byte_cnt_q == 4'd15) begin
          byte_cnt_d = 4'd0;
          wd_d       = '0;
          state_d    = StWait;
        end else begin
          byte_cnt_d = byte_cnt_q + 4'd1;
        end
      end
      StWait: begin
        // done wins over the watchdog in the final WAIT cycle
        if (core_done_i) begin
          cap_d   = {cap_q[119:0], core_ct_i};
          state_d = StUnload;
        end else if (wd_q == WdLast) begin
          wd_d    = WdMax;
          tmo_d   = 1'b1;
          state_d = StIdle;
        end else if (wd_q != WdMax) begin
          wd_d = wd_q + 1'b1;
        end
      end
      StUnload: begin
        cap_d = {cap_q[119:0], core_ct_i};
        if (byte_cnt_q == 4'd14) begin
          byte_cnt_d = 4'd0;
          // publish on entry to DONE so ctxt_o is valid alongside result_valid_o
          ctxt_d     = {cap_q[119:0], core_ct_i};
          state_d    = StDone;
        end else begin
          byte_cnt_d = byte_cnt_q + 4'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pt_sh_q    <= '0;
      key_sh_q   <= '0;
      cap_q      <= '0;
      ctxt_q     <= '0;
      byte_cnt_q <= '0;
      wd_q       <= '0;
      tmo_q      <= 1'b0;
      trg_cnt_q  <= '0;
      trg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pt_sh_q    <= pt_sh_d;
      key_sh_q   <= key_sh_d;
      cap_q      <= cap_d;
      ctxt_q     <= ctxt_d;
      byte_cnt_q <= byte_cnt_d;
      wd_q       <= wd_d;
      tmo_q      <= tmo_d;
      trg_cnt_q  <= trg_cnt_d;
      trg_q      <= (trg_cnt_q == TrgOne);
    end
  end

  always_comb begin
    busy_o         = (state_q != StIdle);
    result_valid_o = (state_q == StDone);
    core_start_o   = (state_q == StStart);
    core_pt_o      = (state_q == StLoad) ? pt_sh_q[127:120]  : 8'h00;
    core_key_o     = (state_q == StLoad) ? key_sh_q[127:120] : 8'h00;
    ctxt_o         = ctxt_q;
    timeout_err_o  = tmo_q;
    trg_o          = trg_q;
  end

endmodule

// File: tb/tb_aes_dom_seq_ctrl.sv
// Bench for aes_dom_seq_ctrl: a behavioural core model drives done/ct; expected ciphertexts are
// queued at start and checked when result_valid fires.
module tb_aes_dom_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_we_i = 1'b0, trg_we_i = 1'b0, start_i = 1'b0, core_done_i = 1'b0;
  logic [127:0] ptxt_i = '0, key_i = '0;
  logic [7:0]   trg_delay_i = '0, core_ct_i = '0;
  logic         busy_o, result_valid_o, timeout_err_o, trg_o, core_start_o;
  logic [127:0] ctxt_o;
  logic [7:0]   core_pt_o, core_key_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rv_cnt = 0;
  int trg_cnt = 0;
  int trg_cyc = -1;
  logic [127:0] exp_q[$];

  localparam logic [127:0] PA   = 128'h0102030405060708090a0b0c0d0e0f10;
  localparam logic [127:0] KA   = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PB   = 128'hdeadbeef00112233445566778899aabb;
  localparam logic [127:0] PC   = 128'h5555aaaa5555aaaa1234567887654321;
  localparam logic [127:0] CTA  = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
  localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_dom_seq_ctrl #(.TIMEOUT_W(4), .TRG_W(8)) dut (
    .clk(clk), .rst(rst), .load_we_i(load_we_i), .ptxt_i(ptxt_i), .key_i(key_i),
    .trg_we_i(trg_we_i), .trg_delay_i(trg_delay_i), .start_i(start_i), .busy_o(busy_o),
    .result_valid_o(result_valid_o), .ctxt_o(ctxt_o), .timeout_err_o(timeout_err_o),
    .trg_o(trg_o), .core_start_o(core_start_o), .core_pt_o(core_pt_o),
    .core_key_o(core_key_o), .core_done_i(core_done_i), .core_ct_i(core_ct_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard pop on result_valid; trigger bookkeeping relative to the start cycle.
  always @(negedge clk) begin
    if (result_valid_o) begin
      rv_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_ctxt: unexpected result_valid, ctxt=%h", ctxt_o);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (ctxt_o !== e) begin
          errors++;
          $display("FAIL sb_ctxt: got %h expected %h", ctxt_o, e);
        end
      end
    end
    if (trg_o) begin
      trg_cnt++;
      trg_cyc = cyc - start_cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] pt, input logic [127:0] key);
    step();
    load_we_i = 1'b1; ptxt_i = pt; key_i = key;
    step();
    load_we_i = 1'b0;
  endtask

  task automatic set_trg(input logic [7:0] d);
    step();
    trg_we_i = 1'b1; trg_delay_i = d;
    step();
    trg_we_i = 1'b0;
  endtask

  // One full run against the core model. trg_at < 0 means no trigger expected.
  task automatic do_run(input logic [127:0] exp_pt, input logic [127:0] exp_key,
                        input logic [127:0] ct, input int lat, input int trg_at,
                        input bit poke, input logic [127:0] poke_pt,
                        input bit coinc, input logic [127:0] coinc_pt, input bit b2b);
    int rv0;
    int bad;
    logic [127:0] p, k;
    if (!b2b) step();
    start_i = 1'b1;
    if (coinc) begin load_we_i = 1'b1; ptxt_i = coinc_pt; end
    start_cyc = cyc; rv0 = rv_cnt; trg_cnt = 0; trg_cyc = -1;
    exp_q.push_back(ct);
    step();
    start_i = 1'b0; load_we_i = 1'b0;
    checks++;
    if (core_start_o !== 1'b1 || busy_o !== 1'b1 || timeout_err_o !== 1'b0) begin
      errors++;
      $display("FAIL run_start: core_start=%b busy=%b tmo=%b required 1 1 0",
               core_start_o, busy_o, timeout_err_o);
    end
    p = exp_pt; k = exp_key; bad = 0;
    for (int n = 0; n < 16; n++) begin
      step();
      if (core_pt_o !== p[127:120] || core_key_o !== k[127:120] || core_start_o !== 1'b0) begin
        if (bad == 0)
          $display("FAIL load_stream: byte %0d pt=%h key=%h required %h %h",
                   n, core_pt_o, core_key_o, p[127:120], k[127:120]);
        bad++;
      end
      p = p << 8; k = k << 8;
    end
    checks++;
    if (bad != 0) errors++;
    step();
    if (poke) begin start_i = 1'b1; load_we_i = 1'b1; ptxt_i = poke_pt; end
    for (int i = 0; i < lat; i++) begin
      step();
      start_i = 1'b0; load_we_i = 1'b0;
    end
    core_done_i = 1'b1; core_ct_i = ct[127:120];
    for (int b = 1; b < 16; b++) begin
      step();
      start_i = 1'b0; load_we_i = 1'b0; core_done_i = 1'b0;
      core_ct_i = ct[127-8*b -: 8];
    end
    step();
    core_ct_i = 8'h00;
    if (poke) start_i = 1'b1;
    checks++;
    if (result_valid_o !== 1'b1 || core_pt_o !== 8'h00) begin
      errors++;
      $display("FAIL run_done: result_valid=%b core_pt=%h required 1 00",
               result_valid_o, core_pt_o);
    end
    step();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || result_valid_o !== 1'b0 || rv_cnt !== rv0 + 1) begin
      errors++;
      $display("FAIL run_end: busy=%b rv=%b pulses=%0d required 0 0 1",
               busy_o, result_valid_o, rv_cnt - rv0);
    end
    checks++;
    if ((trg_at < 0 && trg_cnt !== 0) || (trg_at >= 0 && (trg_cnt !== 1 || trg_cyc !== trg_at)))
    begin
      errors++;
      $display("FAIL trigger: pulses=%0d cycle=%0d required cycle %0d", trg_cnt, trg_cyc, trg_at);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({busy_o, result_valid_o, timeout_err_o, trg_o, core_start_o} !== 5'b0 ||
        ctxt_o !== '0 || core_pt_o !== 8'h00 || core_key_o !== 8'h00) begin
      errors++;
      $display("FAIL reset: busy=%b rv=%b tmo=%b trg=%b cs=%b ctxt=%h required all 0",
               busy_o, result_valid_o, timeout_err_o, trg_o, core_start_o, ctxt_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_byte_order();
    load(PA, KA);
    set_trg(8'd5);
    do_run(PA, KA, CTA, 3, 6, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_fips_vector();
    load(FPT, FKEY);
    set_trg(8'd1);
    do_run(FPT, FKEY, FCT, 0, 2, 1'b0, '0, 1'b0, '0, 1'b0);
    set_trg(8'd0);
    do_run(FPT, FKEY, FCT, 5, -1, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_timeout();
    int rv0;
    step();
    start_i = 1'b1; rv0 = rv_cnt; start_cyc = cyc;
    step();
    start_i = 1'b0;
    repeat (16) step();
    step();
    repeat (14) step();
    checks++;
    if (busy_o !== 1'b1 || timeout_err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: busy=%b tmo=%b at WAIT+14 required 1 0", busy_o, timeout_err_o);
    end
    step();
    checks++;
    if (busy_o !== 1'b0 || timeout_err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge: busy=%b tmo=%b at WAIT+15 required 0 1", busy_o, timeout_err_o);
    end
    repeat (3) step();
    checks++;
    if (rv_cnt !== rv0 || ctxt_o !== FCT || timeout_err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: pulses=%0d ctxt=%h tmo=%b required 0 %h 1",
               rv_cnt - rv0, ctxt_o, timeout_err_o, FCT);
    end
    // next run clears the flag; do_run checks tmo=0 in its first busy cycle
    do_run(FPT, FKEY, CTA, 2, -1, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_concurrency();
    load(PA, KA);
    do_run(PA, KA, FCT, 4, -1, 1'b1, PB, 1'b0, '0, 1'b0);
    do_run(PB, KA, CTA, 1, -1, 1'b0, '0, 1'b0, '0, 1'b0);
    do_run(PB, KA, FCT, 2, -1, 1'b0, '0, 1'b1, PC, 1'b0);
    do_run(PC, KA, CTA, 0, -1, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_trg(8'd3);
    do_run(PC, KA, FCT, 0, 4, 1'b0, '0, 1'b0, '0, 1'b0);
    do_run(PC, KA, CTA, 1, 4, 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    load(PA, KA);
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (8) step();
    checks++;
    if (core_pt_o !== 8'h08 || core_key_o !== 8'h08) begin
      errors++;
      $display("FAIL mid_load_byte7: pt=%h key=%h required 08 08", core_pt_o, core_key_o);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({busy_o, result_valid_o, timeout_err_o, trg_o, core_start_o} !== 5'b0 ||
        ctxt_o !== '0 || core_pt_o !== 8'h00 || core_key_o !== 8'h00) begin
      errors++;
      $display("FAIL mid_load_reset: busy=%b cs=%b ctxt=%h pt=%h required all 0",
               busy_o, core_start_o, ctxt_o, core_pt_o);
    end
    rst = 1'b0;
    load(PA, KA);
    do_run(PA, KA, FCT, 2, -1, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_byte_order();
    test_fips_vector();
    test_timeout();
    test_concurrency();
    test_back_to_back();
    test_reset_mid_load();
    repeat (5) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected results never produced", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
